// File: rtl/loader_pkg.sv
// Shared state encoding and default widths for the program loader.
// The optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RST   = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2**DATA_W sum of program words; sum_zero reports whether adding
// the presented word would bring the total to zero.
module loader_checksum
  import loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] word,
  output logic              sum_zero
);

  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_total;

  assign w_total  = r_sum + word;
  assign sum_zero = (w_total == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (clear) begin
      r_sum <= '0;
    end else if (add_en) begin
      r_sum <= w_total;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: streams a program into instruction memory, then resets and starts the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word before the CPU is released.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_sel,
  output logic              im_en_write,
  output logic [ADDR_W-1:0] im_address,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_reset,
  output logic              cpu_start,
  input  logic              cpu_done,
  output logic              busy,
  output logic              error
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_len;
  logic [RST_W-1:0]  r_rstCnt;
  logic              r_error;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_idleLike;
  logic              w_lenOk;
  logic              w_accept;
  logic              w_reject;
  logic              w_beat;
  logic              w_loading;
  logic              w_lastWord;
  logic              w_chkFail;

  assign w_idleLike = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_lenOk    = (load_len != '0) && (load_len <= MAX_LEN);
  assign w_accept   = load_req && w_idleLike && w_lenOk;
  assign w_reject   = load_req && w_idleLike && !w_lenOk;
  assign in_ready   = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_beat     = in_valid && in_ready;
  assign w_loading  = w_beat && (r_state == S_LOAD);
  assign w_lastWord = ((r_count + LEN_ONE) == r_len);

`ifdef LOADER_CHECKSUM_EN
  logic w_sumZero;

  loader_checksum #(.DATA_W(DATA_W)) u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_accept),
    .add_en   (w_loading),
    .word     (in_data),
    .sum_zero (w_sumZero)
  );

  assign w_chkFail = w_beat && (r_state == S_CHECK) && !w_sumZero;
`else
  assign w_chkFail = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept) begin
          w_next = S_LOAD;
        end else if (w_reject) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_loading && w_lastWord) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_RST;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_beat) begin
          w_next = w_sumZero ? S_RST : S_ERROR;
        end
      end
`endif
      S_RST: begin
        if (r_rstCnt == RST_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_done) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write port is registered one cycle behind the accepted beat; count never wraps
  // because LOAD is left on the beat that reaches len.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_len    <= '0;
      r_rstCnt <= '0;
      r_error  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_we <= w_loading;
      if (w_loading) begin
        r_addr  <= r_count[ADDR_W-1:0];
        r_data  <= in_data;
        r_count <= r_count + LEN_ONE;
      end
      if (w_accept) begin
        r_count <= '0;
        r_len   <= load_len;
        r_error <= 1'b0;
      end else if (w_reject || w_chkFail) begin
        r_error <= 1'b1;
      end
      if (r_state == S_RST) begin
        r_rstCnt <= r_rstCnt + RST_W'(1);
      end else begin
        r_rstCnt <= '0;
      end
    end
  end

  assign im_sel      = in_ready || r_we;
  assign im_en_write = r_we;
  assign im_address  = r_addr;
  assign im_data     = r_data;
  assign cpu_reset   = (r_state != S_RUN);
  assign cpu_start   = (r_state == S_RUN);
  assign busy        = (r_state == S_LOAD) || (r_state == S_CHECK) ||
                       (r_state == S_RST)  || (r_state == S_RUN);
  assign error       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; checksum cases run only when
// LOADER_CHECKSUM_EN is defined for the build.
module tb_program_loader;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int RST_CYCLES = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_req = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              im_sel;
  logic              im_en_write;
  logic [ADDR_W-1:0] im_address;
  logic [DATA_W-1:0] im_data;
  logic              cpu_reset;
  logic              cpu_start;
  logic              cpu_done = 1'b0;
  logic              busy;
  logic              error;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit inValid;
    bit expBusy;
    bit expError;
    bit expReady;
  } vec_t;

  wr_t               wrQ[$];
  logic [DATA_W-1:0] progWords[1024];
  vec_t              vecs[5];
  int                checks = 0;
  int                errors = 0;

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .load_len    (load_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .im_sel      (im_sel),
    .im_en_write (im_en_write),
    .im_address  (im_address),
    .im_data     (im_data),
    .cpu_reset   (cpu_reset),
    .cpu_start   (cpu_start),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_en_write === 1'b1) begin
      wrQ.push_back('{sel: im_sel, addr: im_address, data: im_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failCheck(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    cpu_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    applyReset();
    wrQ.delete();
    in_valid = v.inValid;
    in_data  = 16'hBEEF;
    load_len = (ADDR_W+1)'(v.len);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checkOutput($sformatf("tbl_busy_len%0d", v.len), busy, v.expBusy);
    checkOutput($sformatf("tbl_error_len%0d", v.len), error, v.expError);
    checkOutput($sformatf("tbl_ready_len%0d", v.len), in_ready, v.expReady);
    checkOutput($sformatf("tbl_cpu_reset_len%0d", v.len), cpu_reset, 1);
    repeat (3) tick();
    checkOutput($sformatf("tbl_no_write_len%0d", v.len), wrQ.size(), 0);
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] w, input int gapMode);
    int gaps;
    int n;
    gaps = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 3));
    repeat (gaps) begin
      in_valid = 1'b0;
      in_data  = DATA_W'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) failCheck("ready_timeout");
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  task automatic checkWrites(input int len);
    int m;
    checkOutput("wr_count", wrQ.size(), len);
    m = (wrQ.size() < len) ? wrQ.size() : len;
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("wr_addr[%0d]", i), 32'(wrQ[i].addr), i);
      checkOutput($sformatf("wr_data[%0d]", i), 32'(wrQ[i].data), 32'(progWords[i]));
      checkOutput($sformatf("wr_sel[%0d]", i), 32'(wrQ[i].sel), 1);
    end
  endtask

  // Full boot: load len words from progWords, then reset pulse, run and done.
  task automatic runLoad(input int len, input int gapMode, input bit badChk);
    logic [DATA_W-1:0] sum;
    int rc;
    int n;
    int starts;
    sum = '0;
    wrQ.delete();
    load_len = (ADDR_W+1)'(len);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checkOutput("load_busy", busy, 1);
    checkOutput("load_error_clear", error, 0);
    checkOutput("load_cpu_reset", cpu_reset, 1);
    checkOutput("load_sel", im_sel, 1);
    for (int i = 0; i < len; i++) begin
      sendWord(progWords[i], gapMode);
      sum = sum + progWords[i];
    end
`ifdef LOADER_CHECKSUM_EN
    sendWord(badChk ? DATA_W'(-sum + 16'd1) : DATA_W'(-sum), gapMode);
`endif
    checkOutput("ready_drop", in_ready, 0);
    if (badChk) begin
      starts = 0;
      repeat (20) begin
        if (cpu_start === 1'b1) starts++;
        tick();
      end
      checkOutput("chk_start_never", starts, 0);
      checkOutput("chk_error", error, 1);
      checkOutput("chk_busy", busy, 0);
      checkOutput("chk_cpu_reset", cpu_reset, 1);
      checkWrites(len);
      return;
    end
    rc = 0;
    n  = 0;
    while (cpu_start !== 1'b1 && n < 50) begin
      if (cpu_reset === 1'b1 && busy === 1'b1) rc++;
      tick();
      n++;
    end
    if (n == 50) failCheck("start_timeout");
    checkOutput("rst_cycles", rc, RST_CYCLES);
    checkOutput("run_cpu_reset", cpu_reset, 0);
    checkOutput("run_busy", busy, 1);
    checkWrites(len);
    repeat (3) tick();
    load_len = (ADDR_W+1)'(3);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick();
    checkOutput("run_ignore_req_start", cpu_start, 1);
    checkOutput("run_ignore_req_ready", in_ready, 0);
    checkOutput("run_ignore_req_writes", wrQ.size(), len);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    checkOutput("done_start", cpu_start, 0);
    checkOutput("done_busy", busy, 0);
    checkOutput("done_error", error, 0);
  endtask

  initial begin
    vecs[0] = '{len: 0,    inValid: 1'b1, expBusy: 1'b0, expError: 1'b1, expReady: 1'b0};
    vecs[1] = '{len: 1025, inValid: 1'b1, expBusy: 1'b0, expError: 1'b1, expReady: 1'b0};
    vecs[2] = '{len: 2047, inValid: 1'b1, expBusy: 1'b0, expError: 1'b1, expReady: 1'b0};
    vecs[3] = '{len: 1,    inValid: 1'b0, expBusy: 1'b1, expError: 1'b0, expReady: 1'b1};
    vecs[4] = '{len: 1024, inValid: 1'b0, expBusy: 1'b1, expError: 1'b0, expReady: 1'b1};

    #2;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_im_sel", im_sel, 0);
    checkOutput("rst_im_en_write", im_en_write, 0);
    checkOutput("rst_im_address", im_address, 0);
    checkOutput("rst_im_data", im_data, 0);
    checkOutput("rst_cpu_reset", cpu_reset, 1);
    checkOutput("rst_cpu_start", cpu_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_error", error, 0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    applyReset();
    load_len = '0;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    checkOutput("sticky_error", error, 1);

    $display("[TB] fixed program, back-to-back");
    progWords[0] = 16'h4004;
    progWords[1] = 16'h7000;
    progWords[2] = 16'h4002;
    runLoad(3, 0, 1'b0);

    $display("[TB] toggling valid, len 2");
    progWords[0] = 16'hA5A5;
    progWords[1] = 16'h5A5A;
    runLoad(2, 1, 1'b0);

    $display("[TB] async reset mid-load");
    for (int i = 0; i < 4; i++) progWords[i] = DATA_W'($urandom);
    wrQ.delete();
    load_len = (ADDR_W+1)'(4);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    sendWord(progWords[0], 0);
    sendWord(progWords[1], 0);
    tick();
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_cpu_reset", cpu_reset, 1);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    checkWrites(2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) progWords[i] = DATA_W'($urandom);
    runLoad(4, 0, 1'b0);

    $display("[TB] randomized programs");
    for (int k = 0; k < 6; k++) begin
      int len;
      len = int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) progWords[i] = DATA_W'($urandom);
      runLoad(len, 2, 1'b0);
    end

    $display("[TB] maximum length program");
    for (int i = 0; i < 1024; i++) progWords[i] = DATA_W'($urandom);
    runLoad(1024, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum cases");
    progWords[0] = 16'h0001;
    progWords[1] = 16'h0002;
    runLoad(2, 0, 1'b1);
    runLoad(2, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
